// File: rtl/lab3_pkg.sv
`default_nettype none
// ============================================================================
// lab3_pkg : shared constants and FSM state encoding for the Lab3 serial
//            pattern transmitter and the detectors' bench.
// Rev 1.0
// ============================================================================
package lab3_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

endpackage : lab3_pkg
`default_nettype wire

// File: rtl/lab3_pattern_tx_if.sv
`default_nettype none
// ============================================================================
// lab3_pattern_tx_if : request/status bundle between a controller (master)
//                      and the pattern transmitter (slave).
// Rev 1.0
// ============================================================================
interface lab3_pattern_tx_if
  import lab3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             x;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps,
    input  x, bit_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps,
    output x, bit_valid, busy, done
  );

endinterface : lab3_pattern_tx_if
`default_nettype wire

// File: rtl/lab3_piso.sv
`default_nettype none
// ============================================================================
// lab3_piso : WIDTH-bit parallel-in/serial-out register, MSB first, zero fill.
// Rev 1.0
// ============================================================================
module lab3_piso
  import lab3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic             shift_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic                  msb_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = data_q[WIDTH-1];

endmodule : lab3_piso
`default_nettype wire

// File: rtl/lab3_pattern_tx.sv
`default_nettype none
// ============================================================================
// lab3_pattern_tx : serial pattern transmitter driving the detectors' x input.
//                   Define LAB3_TX_GAP_EN for one idle cycle between repeats.
// Rev 1.0
// ============================================================================
module lab3_pattern_tx
  import lab3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) (
  input  wire logic         clock,
  input  wire logic         reset,
  lab3_pattern_tx_if.slave  bus
);

  localparam int                CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [REP_W-1:0] rep_q;
  logic [WIDTH-1:0] pat_q;
  logic             bit_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             w_accept;
  logic             w_more;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_load_data;
  logic             w_msb;

  assign w_accept = (state_q == S_IDLE) && bus.start && (bus.reps != '0);
  assign w_more   = (rep_q > REP_W'(1));

  // The serial register doubles as the x output flop; it has emptied to zero
  // by the time the last bit is consumed, so IDLE and GAP both show x=0.
  always_comb begin
    w_load      = w_accept;
    w_shift     = 1'b0;
    w_load_data = (state_q == S_IDLE) ? bus.pattern : pat_q;
    if (state_q == S_SHIFT) begin
`ifdef LAB3_TX_GAP_EN
      w_shift = 1'b1;
`else
      w_load  = (bit_cnt_q == '0) && w_more;
      w_shift = !w_load;
`endif
    end
`ifdef LAB3_TX_GAP_EN
    if (state_q == S_GAP) begin
      w_load = 1'b1;
    end
`endif
  end

  lab3_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clock),
    .rst     (reset),
    .load_i  (w_load),
    .shift_i (w_shift),
    .data_i  (w_load_data),
    .msb_o   (w_msb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rep_q       <= '0;
      pat_q       <= '0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            state_q     <= S_SHIFT;
            bit_cnt_q   <= C_LAST;
            rep_q       <= bus.reps;
            pat_q       <= bus.pattern;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end else if (w_more) begin
            rep_q     <= rep_q - REP_W'(1);
            bit_cnt_q <= C_LAST;
`ifdef LAB3_TX_GAP_EN
            state_q     <= S_GAP;
            bit_valid_q <= 1'b0;
`endif
          end else begin
            state_q     <= S_IDLE;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`ifdef LAB3_TX_GAP_EN
        S_GAP: begin
          state_q     <= S_SHIFT;
          bit_valid_q <= 1'b1;
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          bit_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x         = w_msb;
  assign bus.bit_valid = bit_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule : lab3_pattern_tx
`default_nettype wire

// File: tb/tb_lab3_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_lab3_pattern_tx : directed scoreboard bench for lab3_pattern_tx.
// Rev 1.0
// ============================================================================
module tb_lab3_pattern_tx;
  import lab3_pkg::*;

`ifdef LAB3_TX_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  typedef struct {
    int   cyc;
    logic x;
    logic bv;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t e;

  lab3_pattern_tx_if #(.WIDTH(8), .REP_W(4)) bus ();

  lab3_pattern_tx #(.WIDTH(8), .REP_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the DUT shows activity must match the queue head.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed cyc=%0d: no output seen, want x=%b bv=%b busy=%b done=%b",
               q[0].cyc, q[0].x, q[0].bv, q[0].busy, q[0].done);
      q.delete(0);
    end
    if (bus.bit_valid || bus.busy || bus.done) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected cyc=%0d: got x=%b bv=%b busy=%b done=%b, want no activity",
                 cyc, bus.x, bus.bit_valid, bus.busy, bus.done);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.x !== bus.x || e.bv !== bus.bit_valid ||
            e.busy !== bus.busy || e.done !== bus.done) begin
          failures++;
          $display("FAIL stream: got cyc=%0d x=%b bv=%b busy=%b done=%b, want cyc=%0d x=%b bv=%b busy=%b done=%b",
                   cyc, bus.x, bus.bit_valid, bus.busy, bus.done,
                   e.cyc, e.x, e.bv, e.busy, e.done);
        end
      end
    end else begin
      checks++;
      if (bus.x !== 1'b0) begin
        failures++;
        $display("FAIL x_idle cyc=%0d: got x=%b, want 0", cyc, bus.x);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_x"},    int'(bus.x),         0);
    check({name, "_bv"},   int'(bus.bit_valid), 0);
    check({name, "_busy"}, int'(bus.busy),      0);
    check({name, "_done"}, int'(bus.done),      0);
  endtask

  // Issue a start at the current negedge and push the expected stream.
  task automatic send(input logic [7:0] pat, input int reps,
                      output int c0, output int dc);
    int t;
    bus.pattern = pat;
    bus.reps    = 4'(reps);
    bus.start   = 1'b1;
    c0 = cyc;
    t  = c0 + 1;
    if (reps != 0) begin
      for (int r = 0; r < reps; r++) begin
        for (int i = 0; i < 8; i++) begin
          q.push_back('{t, pat[7-i], 1'b1, 1'b1, 1'b0});
          t++;
        end
        if (GAP != 0 && r < reps - 1) begin
          q.push_back('{t, 1'b0, 1'b0, 1'b1, 1'b0});
          t++;
        end
      end
      q.push_back('{t, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    dc = t;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout at cyc=%0d, want completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, dc;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    rst         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic single send
    send(8'b1011_0010, 1, c0, dc);
    wait_until(dc + 1);
    check("basic_drain", q.size(), 0);

    // Two repetitions of A5 (gap or contiguous depending on build)
    send(8'hA5, 2, c0, dc);
    wait_until(dc + 1);
    check("rep2_drain", q.size(), 0);

    // Three repetitions, then a new start in the done cycle
    send(8'h3C, 3, c0, dc);
    wait_until(dc);
    send(8'h81, 1, c0, dc);
    wait_until(dc + 1);
    check("b2b_drain", q.size(), 0);

    // Zero repetitions are ignored
    send(8'h55, 0, c0, dc);
    repeat (12) @(negedge clk);
    check("zero_reps_drain", q.size(), 0);

    // Start while busy, plus live input changes, must not disturb the stream
    send(8'hC6, 1, c0, dc);
    wait_until(c0 + 3);
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.reps    = 4'd5;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.pattern = 8'h00;
    wait_until(dc + 1);
    check("busy_start_drain", q.size(), 0);

    // Reset during bit 4 abandons the pattern; reset beats a concurrent start
    send(8'h9B, 1, c0, dc);
    wait_until(c0 + 5);
    rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > c0 + 5) q.pop_back();
    @(negedge clk);
    check_quiet("mid_reset");
    bus.start   = 1'b1;
    bus.pattern = 8'hE7;
    bus.reps    = 4'd1;
    @(negedge clk);
    check_quiet("reset_vs_start");
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    send(8'h9B, 1, c0, dc);
    wait_until(dc + 1);
    check("after_reset_drain", q.size(), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lab3_pattern_tx
`default_nettype wire
